// File: rtl/perf_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : perf_pkg                                           |
// | Description : Shared state encoding and default width for the    |
// |               performance measurement window controller.         |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package perf_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    CAPT = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/window_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : window_timer                                       |
// | Description : Remaining-cycle down-counter for a measurement     |
// |               window. A loaded value of 0 never expires.         |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module window_timer
  import perf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] len_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_d;

  // Load wins over decrement; zero (unbounded) saturates and never counts down
  always_comb begin
    rem_d = rem_q;
    if (load_i) begin
      rem_d = len_i;
    end else if (dec_i && (rem_q != '0)) begin
      rem_d = rem_q - WIDTH'(1);
    end
  end

  // Remaining-cycle register
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  // Last bounded cycle of the window
  assign last_o = (rem_q == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/perf_window_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : perf_window_ctrl                                   |
// | Description : Opens a measurement window on an external cycle    |
// |               counter, closes it on expiry or stop, captures the |
// |               count and flags counter wrap.                      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module perf_window_ctrl
  import perf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] win_len_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             cnt_en_o,
  output logic             cnt_clear_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             overflow_o
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;
  logic             rst_clr_q;   // holds the counter clear for the cycle after reset
  logic             start_acc;
  logic             timer_last;

  // A start only counts in IDLE and when no abort is requested alongside it
  assign start_acc = (state_q == IDLE) && start_i && !clear_i;

  window_timer #(
    .WIDTH (WIDTH)
  ) u_window_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (start_acc),
    .len_i  (win_len_i),
    .dec_i  (state_q == RUN),
    .last_o (timer_last)
  );

  // Next-state decode; clear_i overrides every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = CLR;
      CLR:     state_d = RUN;
      RUN:     if (stop_i || timer_last) state_d = CAPT;
      CAPT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
    end
  end

  // State, captured result, overflow flag and post-reset counter clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      result_q   <= '0;
      overflow_q <= 1'b0;
      rst_clr_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      rst_clr_q <= 1'b0;
      if ((state_q == CAPT) && !clear_i) begin
        result_q <= cnt_i;
      end
      if (start_acc) begin
        overflow_q <= 1'b0;
      end else if (cnt_en_o && (cnt_i == '1)) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Counter control is masked by clear_i so enable and clear are exclusive
  assign cnt_en_o    = (state_q == RUN) && !clear_i;
  assign cnt_clear_o = (state_q == CLR) || clear_i || rst_clr_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == CAPT);
  assign result_o    = result_q;
  assign overflow_o  = overflow_q;

endmodule
`default_nettype wire
